// File: rtl/wb_sram_slave_if.sv
// Wishbone bus bundle (wb_if) shared by the interconnect and its responders.
// The slave modport is what a responder such as wb_sram_slave connects to.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   ADR;
    logic [2:0]      CTI;
    logic [1:0]      BTE;
    logic [DW-1:0]   DAT_W;
    logic [DW-1:0]   DAT_R;
    logic            CYC;
    logic [DW/8-1:0] SEL;
    logic            STB;
    logic            WE;
    logic            ACK;
    logic            ERR;

    modport slave (
        input  ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
        output DAT_R, ACK, ERR
    );

    modport master (
        output ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
        input  DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone word-memory responder: classic cycles, incrementing/wrapping bursts, byte writes, wait states.
// Optional error responses (reserved CTI, out-of-range address) enabled by defining WB_SRAM_SLAVE_ERR_EN.
module wb_sram_slave_chk #(
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rstn,
    input logic          ack,
    input logic          err,
    input logic [DW-1:0] dat
);
    a_ack_err_exclusive: assert property (@(posedge clk) disable iff (!rstn) !(ack && err))
        else $error("wb_sram_slave: ACK and ERR high together");

    a_dat_zero_idle: assert property (@(posedge clk) disable iff (!rstn) !ack |-> (dat == '0))
        else $error("wb_sram_slave: DAT_R nonzero without ACK");
endmodule

module wb_sram_slave #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int WAIT_STATES   = 0
) (
    input logic clk,
    input logic rstn,
    wb_if.slave s
);
    localparam int OFS   = $clog2(WB_DATA_WIDTH / 8);
    localparam int NSEL  = WB_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CLASSIC = 3'd2,
        ST_BURST   = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    state_t                     state_r, state_s;
    logic [3:0]                 cnt_r, cnt_s;
    logic [MEM_ADDR_BITS-1:0]   idx_r, idx_s;
    logic [MEM_ADDR_BITS-1:0]   rd_idx_s;
    logic [2:0]                 cti_r, cti_s;
    logic [1:0]                 bte_r, bte_s;
    logic                       we_r, we_s;
    logic                       bad_r, bad_s;
    logic                       req_bad_s;
    logic                       ack_r, ack_s;
    logic                       err_r, err_s;
    logic                       load_s;
    logic                       wr_s;
    logic [WB_DATA_WIDTH-1:0]   dat_r, dat_s;
    logic                       unused_adr_s;

    logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];

    // Next beat index: the low 2/3/4 bits wrap for BTE 01/10/11, the full index wraps for linear.
    function automatic logic [MEM_ADDR_BITS-1:0] wrap_next(
        input logic [MEM_ADDR_BITS-1:0] idx,
        input logic [1:0]               bte
    );
        logic [MEM_ADDR_BITS-1:0] mask;
        logic [MEM_ADDR_BITS-1:0] inc;
        case (bte)
            2'b01:   mask = MEM_ADDR_BITS'(4'd3);
            2'b10:   mask = MEM_ADDR_BITS'(4'd7);
            2'b11:   mask = MEM_ADDR_BITS'(4'd15);
            default: mask = '1;
        endcase
        inc = idx + MEM_ADDR_BITS'(1'b1);
        return (idx & ~mask) | (inc & mask);
    endfunction

`ifdef WB_SRAM_SLAVE_ERR_EN
    function automatic logic cti_reserved(input logic [2:0] cti);
        logic r;
        case (cti)
            CTI_CLASSIC, CTI_INCR, CTI_END: r = 1'b0;
            default:                        r = 1'b1;
        endcase
        return r;
    endfunction

    logic [WB_ADDR_WIDTH-1:0] upper_s;
    assign upper_s   = s.ADR >> (OFS + MEM_ADDR_BITS);
    assign req_bad_s = cti_reserved(s.CTI) | (|upper_s);
`else
    assign req_bad_s = 1'b0;
`endif

    // Byte offset bits (and, without error checking, the alias bits) carry no meaning here.
    assign unused_adr_s = ^s.ADR;

    // Next-state, request capture and handshake decisions.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        cti_s    = cti_r;
        bte_s    = bte_r;
        we_s     = we_r;
        bad_s    = bad_r;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        load_s   = 1'b0;
        wr_s     = 1'b0;
        rd_idx_s = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (s.CYC && s.STB) begin
                    state_s = ST_WAIT;
                    cnt_s   = 4'd0;
                    idx_s   = s.ADR[OFS +: MEM_ADDR_BITS];
                    cti_s   = s.CTI;
                    bte_s   = s.BTE;
                    we_s    = s.WE;
                    bad_s   = req_bad_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!s.CYC) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'(WAIT_STATES)) begin
                    if (bad_r) begin
                        state_s = ST_CLASSIC;
                        err_s   = 1'b1;
                    end else if (cti_r == CTI_INCR) begin
                        state_s = ST_BURST;
                        ack_s   = 1'b1;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_CLASSIC;
                        ack_s   = 1'b1;
                        load_s  = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_CLASSIC: begin
                if (!s.CYC) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TURN;
                    wr_s    = ack_r && s.STB && we_r;
                end
            end
            ST_BURST: begin
                if (!s.CYC) begin
                    state_s = ST_IDLE;
                end else if (ack_r && s.STB) begin
                    wr_s = we_r;
                    // Anything but a continuing incrementing CTI ends the burst on this beat.
                    if (s.CTI == CTI_INCR) begin
                        idx_s    = wrap_next(idx_r, bte_r);
                        rd_idx_s = wrap_next(idx_r, bte_r);
                        ack_s    = 1'b1;
                        load_s   = 1'b1;
                    end else begin
                        state_s = ST_TURN;
                    end
                end else if (s.STB) begin
                    ack_s  = 1'b1;
                    load_s = 1'b1;
                end else begin
                    ack_s = 1'b0;
                end
            end
            ST_TURN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read data is the addressed word while acknowledging and zero otherwise.
    always_comb begin
        dat_s = '0;
        if (load_s) begin
            dat_s = mem[rd_idx_s];
        end else begin
            dat_s = '0;
        end
    end

    // State, captured request and registered bus outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            cti_r   <= 3'b000;
            bte_r   <= 2'b00;
            we_r    <= 1'b0;
            bad_r   <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            cti_r   <= cti_s;
            bte_r   <= bte_s;
            we_r    <= we_s;
            bad_r   <= bad_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            dat_r   <= dat_s;
        end
    end

    // Byte-enabled write of a completed beat; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSEL; i++) begin
            if (wr_s && s.SEL[i]) begin
                mem[idx_r][i*8 +: 8] <= s.DAT_W[i*8 +: 8];
            end
        end
    end

    assign s.ACK   = ack_r;
    assign s.ERR   = err_r;
    assign s.DAT_R = dat_r;

    wb_sram_slave_chk #(
        .DW (WB_DATA_WIDTH)
    ) u_chk (
        .clk  (clk),
        .rstn (rstn),
        .ack  (ack_r),
        .err  (err_r),
        .dat  (dat_r)
    );
endmodule
